// File: rtl/alu4_pkg.sv
// Shared definitions for the 4-bit Mano-style ALU.
// Arithmetic opcodes are {select[1:0], carry_in}; logic codes are the full select.
package alu4_pkg;

    localparam int ALU_W = 4;

    typedef enum logic [2:0] {
        TRANSFER      = 3'd0,
        INCREMENT     = 3'd1,
        ADD           = 3'd2,
        ADD_INCREMENT = 3'd3,
        ADD_INVERT    = 3'd4,
        SUBTRACT      = 3'd5,
        DECREMENT     = 3'd6,
        ADD_CARRY     = 3'd7
    } arith_op_e;

    localparam logic [2:0] SEL_AND = 3'd4;
    localparam logic [2:0] SEL_OR  = 3'd5;
    localparam logic [2:0] SEL_XOR = 3'd6;
    localparam logic [2:0] SEL_NOT = 3'd7;

endpackage

// File: rtl/alu4_alu1_slice.sv
// One bit of the ALU: operand-Y mux, full adder and logic mux.
// The ripple carry is produced regardless of mode; the top gates it.
module alu1_slice
    import alu4_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       c_i,
    input  logic [2:0] select,
    output logic       f_i,
    output logic       c_next
);

    logic y_bit;
    logic sum_bit;
    logic logic_bit;

    always_comb begin
        y_bit = 1'b0;
        case (select[1:0])
            2'b00:   y_bit = 1'b0;
            2'b01:   y_bit = b_i;
            2'b10:   y_bit = ~b_i;
            default: y_bit = 1'b1;
        endcase
    end

    assign sum_bit = a_i ^ y_bit ^ c_i;
    assign c_next  = (a_i & y_bit) | (c_i & (a_i ^ y_bit));

    always_comb begin
        logic_bit = 1'b0;
        case (select)
            SEL_AND: logic_bit = a_i & b_i;
            SEL_OR:  logic_bit = a_i | b_i;
            SEL_XOR: logic_bit = a_i ^ b_i;
            SEL_NOT: logic_bit = ~a_i;
            default: logic_bit = 1'b0;
        endcase
    end

    assign f_i = select[2] ? logic_bit : sum_bit;

endmodule

// File: rtl/alu4.sv
// 4-bit registered ALU: four ripple-chained slices feeding result/carry registers.
// Carry is forced to zero in logic mode; reset is synchronous and active-low.
module alu4
    import alu4_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic             carry_in,
    input  logic [2:0]       select,
    output logic [ALU_W-1:0] out,
    output logic             carry_out
);

    logic [ALU_W:0]   carry_chain;
    logic [ALU_W-1:0] out_next;
    logic             carry_next;
    logic [ALU_W-1:0] out_reg;
    logic             carry_reg;

    assign carry_chain[0] = carry_in;

    generate
        for (genvar gi = 0; gi < ALU_W; gi++) begin : g_slice
            alu1_slice u_slice (
                .a_i    (a[gi]),
                .b_i    (b[gi]),
                .c_i    (carry_chain[gi]),
                .select (select),
                .f_i    (out_next[gi]),
                .c_next (carry_chain[gi+1])
            );
        end
    endgenerate

    assign carry_next = select[2] ? 1'b0 : carry_chain[ALU_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_reg   <= '0;
            carry_reg <= 1'b0;
        end else begin
            out_reg   <= out_next;
            carry_reg <= carry_next;
        end
    end

    assign out       = out_reg;
    assign carry_out = carry_reg;

endmodule

// File: tb/tb_alu4.sv
// Directed and exhaustive checks of alu4 against hand values and the a+Y+cin rule.
`timescale 1ns/1ps
module tb_alu4;
    import alu4_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       carry_in;
    logic [2:0] select;
    logic [3:0] out;
    logic       carry_out;

    int errors = 0;
    int checks = 0;

    alu4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .select    (select),
        .out       (out),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] model(input logic [3:0] ma, input logic [3:0] mb,
                                         input logic mc, input logic [2:0] ms);
        logic [3:0] y;
        logic [4:0] res;
        y = 4'h0;
        res = 5'h0;
        if (!ms[2]) begin
            case (ms[1:0])
                2'b00:   y = 4'h0;
                2'b01:   y = mb;
                2'b10:   y = ~mb;
                default: y = 4'hF;
            endcase
            res = {1'b0, ma} + {1'b0, y} + {4'b0, mc};
        end else begin
            case (ms[1:0])
                2'b00:   res = {1'b0, ma & mb};
                2'b01:   res = {1'b0, ma | mb};
                2'b10:   res = {1'b0, ma ^ mb};
                default: res = {1'b0, ~ma};
            endcase
        end
        return res;
    endfunction

    task automatic drive(input logic [3:0] ta, input logic [3:0] tb_v,
                         input logic tc, input logic [2:0] ts);
        a = ta;
        b = tb_v;
        carry_in = tc;
        select = ts;
    endtask

    task automatic step_check(input string tag, input logic [3:0] exp_out, input logic exp_c);
        @(posedge clk);
        #1;
        checks++;
        assert (out === exp_out) else begin
            errors++;
            $error("FAIL %s out: got %h expected %h", tag, out, exp_out);
        end
        checks++;
        assert (carry_out === exp_c) else begin
            errors++;
            $error("FAIL %s carry: got %b expected %b", tag, carry_out, exp_c);
        end
        $display("%s a=%h b=%h cin=%b sel=%0d -> out=%h c=%b", tag, a, b, carry_in, select, out, carry_out);
    endtask

    initial begin
        logic [4:0] exp;
        rst_n = 1'b0;
        drive(4'hF, 4'hF, 1'b1, 3'd2);
        @(posedge clk);
        step_check("reset", 4'h0, 1'b0);
        rst_n = 1'b1;
        // select=2, cin=1 is SUBTRACT: F - F = 0 with no borrow
        step_check("reset_release", 4'h0, 1'b1);

        drive(4'hF, 4'h0, 1'b1, 3'd0); step_check("inc_F",      4'h0, 1'b1);
        drive(4'h0, 4'h0, 1'b0, 3'd3); step_check("dec_0",      4'hF, 1'b0);
        drive(4'h3, 4'h5, 1'b1, 3'd2); step_check("sub_3_5",    4'hE, 1'b0);
        drive(4'h5, 4'h3, 1'b1, 3'd2); step_check("sub_5_3",    4'h2, 1'b1);
        drive(4'h7, 4'h2, 1'b1, 3'd3); step_check("addc_7",     4'h7, 1'b1);
        drive(4'h9, 4'h6, 1'b0, 3'd0); step_check("xfer_9",     4'h9, 1'b0);
        drive(4'h6, 4'h4, 1'b1, 3'd1); step_check("addinc_6_4", 4'hB, 1'b0);
        drive(4'h6, 4'h4, 1'b0, 3'd2); step_check("addinv_6_4", 4'h1, 1'b1);
        drive(4'h5, 4'h0, 1'b0, 3'd3); step_check("dec_5",      4'h4, 1'b1);

        drive(4'hC, 4'hA, 1'b1, SEL_AND); step_check("and_C_A", 4'h8, 1'b0);
        drive(4'hC, 4'hA, 1'b0, SEL_OR);  step_check("or_C_A",  4'hE, 1'b0);
        drive(4'hC, 4'hA, 1'b1, SEL_XOR); step_check("xor_C_A", 4'h6, 1'b0);
        drive(4'hC, 4'hA, 1'b1, SEL_NOT); step_check("not_C",   4'h3, 1'b0);

        drive(4'h8, 4'h8, 1'b0, 3'd1);    step_check("b2b_add", 4'h0, 1'b1);
        drive(4'hF, 4'h0, 1'b0, SEL_XOR); step_check("b2b_xor", 4'hF, 1'b0);

        // reset must win over a carry-producing operation on the same edge
        drive(4'hF, 4'hF, 1'b1, 3'd1);
        rst_n = 1'b0;
        step_check("reset_override", 4'h0, 1'b0);
        rst_n = 1'b1;

        for (int op = 0; op < 8; op++) begin
            for (int ia = 0; ia < 16; ia++) begin
                for (int ib = 0; ib < 16; ib++) begin
                    drive(4'(ia), 4'(ib), op[0], {1'b0, op[2:1]});
                    exp = model(4'(ia), 4'(ib), op[0], {1'b0, op[2:1]});
                    step_check($sformatf("arith_%s", arith_op_e'(op)), exp[3:0], exp[4]);
                end
            end
        end

        for (int ls = 4; ls < 8; ls++) begin
            for (int c = 0; c < 2; c++) begin
                for (int ia = 0; ia < 16; ia++) begin
                    for (int ib = 0; ib < 16; ib++) begin
                        drive(4'(ia), 4'(ib), c[0], 3'(ls));
                        exp = model(4'(ia), 4'(ib), c[0], 3'(ls));
                        step_check($sformatf("logic_%0d", ls), exp[3:0], 1'b0);
                    end
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
